// File: rtl/n_bit_alu.sv
// rtl/n_bit_alu.sv - registered N-bit MIPS-style ALU (AND/OR/ADD/SUB/SLT/NOR/NAND)
//
// Purpose:
//   Integer ALU built as a ripple chain of N identical 1-bit full-adder slices.
//   The MSB slice also supplies the set-less-than term. Result and zero flag are
//   registered, giving one cycle of latency and one operation per cycle.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous active-high reset (result=0, zero=1)
//   Ainvert  in   1  invert operand a before the slice logic
//   Binvert  in   1  invert operand b before the slice logic
//   Cin      in   1  carry into bit 0 (Op=10 and Op=11 only)
//   Op       in   2  00 AND, 01 OR, 10 ADD, 11 SLT
//   a        in   N  operand A
//   b        in   N  operand B
//   result   out  N  registered result
//   zero     out  1  registered flag, 1 when result == 0

module n_bit_alu #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Ainvert,
  input  logic         Binvert,
  input  logic         Cin,
  input  logic [1:0]   Op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic         zero
);

  logic [N-1:0] a_eff;
  logic [N-1:0] b_eff;
  logic [N-1:0] sum;
  logic         carry_in_msb;
  logic         carry_out_msb;
  logic         set_msb;

  logic [N-1:0] result_d;
  logic [N-1:0] result_q;
  logic         zero_d;
  logic         zero_q;

  // One slice of the chain: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  // The carry is walked through a local variable so the chain is one
  // combinational process rather than a self-referencing vector.
  always_comb begin : ripple
    logic       c;
    logic [1:0] fa;
    a_eff = Ainvert ? ~a : a;
    b_eff = Binvert ? ~b : b;
    // Only the arithmetic ops (Op[1]=1) consume Cin; gating it keeps an
    // undriven Cin out of the chain for AND/OR.
    c = Cin & Op[1];
    sum = '0;
    carry_in_msb = 1'b0;
    fa = 2'b00;
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) begin
        carry_in_msb = c;
      end
      fa = full_add(a_eff[i], b_eff[i], c);
      sum[i] = fa[0];
      c = fa[1];
    end
    carry_out_msb = c;
  end

  // Signed overflow flips the apparent sign of the sum; xor it back to get
  // the true sign, which is the less-than answer.
  assign set_msb = sum[N-1] ^ (carry_in_msb ^ carry_out_msb);

  always_comb begin
    result_d = '0;
    case (Op)
      2'b00:   result_d = a_eff & b_eff;
      2'b01:   result_d = a_eff | b_eff;
      2'b10:   result_d = sum;
      2'b11:   result_d = {{(N-1){1'b0}}, set_msb};
      default: result_d = '0;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_n_bit_alu.sv
// tb/tb_n_bit_alu.sv - self-checking bench for n_bit_alu

module tb_n_bit_alu;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         Ainvert = 1'b0;
  logic         Binvert = 1'b0;
  logic         Cin = 1'b0;
  logic [1:0]   Op = 2'b00;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] result;
  logic         zero;

  int errors = 0;
  int checks = 0;

  n_bit_alu #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .Ainvert (Ainvert),
    .Binvert (Binvert),
    .Cin     (Cin),
    .Op      (Op),
    .a       (a),
    .b       (b),
    .result  (result),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  // Reference: arithmetic on wide integers; SLT takes the sign of the exact
  // (non-wrapping) signed sum.
  function automatic logic [N-1:0] model(input logic ai, input logic bi, input logic ci,
                                         input logic [1:0] op, input logic [N-1:0] x,
                                         input logic [N-1:0] y);
    logic [N-1:0] xa;
    logic [N-1:0] yb;
    logic [N+1:0] wide;
    xa = ai ? ~x : x;
    yb = bi ? ~y : y;
    wide = {xa[N-1], xa[N-1], xa} + {yb[N-1], yb[N-1], yb} + {{(N+1){1'b0}}, ci};
    case (op)
      2'd0:    model = xa & yb;
      2'd1:    model = xa | yb;
      2'd2:    model = wide[N-1:0];
      default: model = {{(N-1){1'b0}}, wide[N+1]};
    endcase
  endfunction

  function automatic logic [N-1:0] rnd_operand();
    logic [N-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(N-1){1'b0}}};
      3:       v = {1'b0, {(N-1){1'b1}}};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic run(input logic ai, input logic bi, input logic ci, input logic [1:0] op,
                     input logic [N-1:0] x, input logic [N-1:0] y);
    @(negedge clk);
    Ainvert = ai;
    Binvert = bi;
    Cin     = ci;
    Op      = op;
    a       = x;
    b       = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++;
    if (result !== '0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_initial: result=%h zero=%b expected result=0 zero=1", result, zero);
    end
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, 1'b0, 1'b0, 2'b10, 64'd5, 64'd7);
    checks++;
    if (result !== 64'd12 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_preload: result=%h zero=%b expected result=c zero=0", result, zero);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (result !== '0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: result=%h zero=%b expected result=0 zero=1", result, zero);
    end
    @(posedge clk);
    #1;
    checks++;
    if (result !== '0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: result=%h zero=%b expected result=0 zero=1", result, zero);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (result !== 64'd12 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: result=%h zero=%b expected result=c zero=0", result, zero);
    end
  endtask

  task automatic test_logic();
    logic [2:0]   ctl [4];
    logic [1:0]   ops [4];
    logic [N-1:0] exp [4];
    ctl[0] = 3'b000; ops[0] = 2'b00; exp[0] = 64'h0000_0000_0000_F000;
    ctl[1] = 3'b000; ops[1] = 2'b01; exp[1] = 64'h0000_0000_0000_FFF0;
    ctl[2] = 3'b110; ops[2] = 2'b00; exp[2] = 64'hFFFF_FFFF_FFFF_000F;
    ctl[3] = 3'b111; ops[3] = 2'b01; exp[3] = 64'hFFFF_FFFF_FFFF_0FFF;
    for (int i = 0; i < 4; i++) begin
      run(ctl[i][2], ctl[i][1], ctl[i][0], ops[i], 64'hF0F0, 64'hFF00);
      checks++;
      if (result !== exp[i] || zero !== 1'b0) begin
        errors++;
        $display("FAIL logic_%0d: result=%h zero=%b expected result=%h zero=0",
                 i, result, zero, exp[i]);
      end
    end
  endtask

  task automatic test_arith();
    logic [2:0]   ctl [8];
    logic [1:0]   ops [8];
    logic [N-1:0] xa  [8];
    logic [N-1:0] yb  [8];
    logic [N-1:0] exp [8];
    ctl[0] = 3'b000; ops[0] = 2'b10; xa[0] = 64'd5;  yb[0] = 64'd7; exp[0] = 64'd12;
    ctl[1] = 3'b000; ops[1] = 2'b10; xa[1] = '1;     yb[1] = 64'd1; exp[1] = 64'd0;
    ctl[2] = 3'b011; ops[2] = 2'b10; xa[2] = 64'd768678178976298;
    yb[2] = 64'd768678178976298; exp[2] = 64'd0;
    ctl[3] = 3'b011; ops[3] = 2'b10; xa[3] = 64'd10; yb[3] = 64'd3; exp[3] = 64'd7;
    ctl[4] = 3'b011; ops[4] = 2'b11; xa[4] = 64'd3;  yb[4] = 64'd5; exp[4] = 64'd1;
    ctl[5] = 3'b011; ops[5] = 2'b11; xa[5] = 64'd5;  yb[5] = 64'd3; exp[5] = 64'd0;
    ctl[6] = 3'b011; ops[6] = 2'b11; xa[6] = '1;     yb[6] = 64'd1; exp[6] = 64'd1;
    ctl[7] = 3'b011; ops[7] = 2'b11; xa[7] = 64'h7FFF_FFFF_FFFF_FFFF;
    yb[7] = '1; exp[7] = 64'd0;
    for (int i = 0; i < 8; i++) begin
      run(ctl[i][2], ctl[i][1], ctl[i][0], ops[i], xa[i], yb[i]);
      checks++;
      if (result !== exp[i] || zero !== (exp[i] == '0)) begin
        errors++;
        $display("FAIL arith_%0d: result=%h zero=%b expected result=%h zero=%b",
                 i, result, zero, exp[i], exp[i] == '0);
      end
    end
  endtask

  task automatic test_x_inputs();
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] exp;
    x = {$urandom, $urandom};
    y = {$urandom, $urandom};
    run(1'b0, 1'b0, 1'bx, 2'b00, x, y);
    exp = x & y;
    checks++;
    if (result !== exp || zero !== (exp == '0)) begin
      errors++;
      $display("FAIL cin_x_and: result=%h zero=%b expected result=%h", result, zero, exp);
    end
    run(1'b0, 1'b0, 1'bx, 2'b01, x, y);
    exp = x | y;
    checks++;
    if (result !== exp || zero !== (exp == '0)) begin
      errors++;
      $display("FAIL cin_x_or: result=%h zero=%b expected result=%h", result, zero, exp);
    end
    run(1'bx, 1'bx, 1'b0, 2'bxx, x, y);
    run(1'b0, 1'b1, 1'b1, 2'b10, x, y);
    exp = x - y;
    checks++;
    if (result !== exp || zero !== (exp == '0)) begin
      errors++;
      $display("FAIL x_recover: result=%h zero=%b expected result=%h", result, zero, exp);
    end
  endtask

  task automatic test_random();
    logic         ai;
    logic         bi;
    logic         ci;
    logic [1:0]   op;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] exp;
    for (int i = 0; i < 300; i++) begin
      ai = 1'($urandom);
      bi = 1'($urandom);
      ci = 1'($urandom);
      op = 2'($urandom);
      x  = rnd_operand();
      y  = (i % 7 == 0) ? x : rnd_operand();
      exp = model(ai, bi, ci, op, x, y);
      run(ai, bi, ci, op, x, y);
      checks++;
      if (result !== exp || zero !== (exp == '0)) begin
        errors++;
        $display("FAIL random_%0d: ctl=%b%b%b op=%b a=%h b=%h result=%h zero=%b expected %h",
                 i, ai, bi, ci, op, x, y, result, zero, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] prev_exp;
    bit           have_prev;
    have_prev = 1'b0;
    prev_exp  = '0;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (have_prev) begin
        checks++;
        if (result !== prev_exp || zero !== (prev_exp == '0)) begin
          errors++;
          $display("FAIL back_to_back_%0d: result=%h zero=%b expected %h",
                   i, result, zero, prev_exp);
        end
      end
      if (i < 40) begin
        Ainvert = 1'($urandom);
        Binvert = 1'($urandom);
        Cin     = 1'($urandom);
        Op      = 2'($urandom);
        a       = rnd_operand();
        b       = rnd_operand();
        prev_exp  = model(Ainvert, Binvert, Cin, Op, a, b);
        have_prev = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_logic();
    test_arith();
    test_x_inputs();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
